// File: rtl/br_service_bridge_pkg.sv
// Shared BrLite bridge types: the payload record, sequence width and TX FSM states.
// Also provides the helper that derives the compact 8-bit source from a PE address.
package DMNIPkg;

  localparam int BR_SEQ_W = 8;

  typedef struct packed {
    logic [3:0]  ksvc;
    logic [15:0] payload;
    logic [15:0] seq_source;
  } br_payload_t;

  typedef enum logic {
    BR_TX_IDLE,
    BR_TX_SEND
  } br_tx_state_t;

  // Compact source is {x[3:0], y[3:0]} of the {x[7:0], y[7:0]} address.
  function automatic logic [7:0] br_compact_src(input logic [15:0] addr);
    return {addr[11:8], addr[3:0]};
  endfunction

endpackage

// File: rtl/br_service_bridge_fifo.sv
// Small synchronous FIFO for the bridge receive path, with a parameterised depth and entry type.
// Full and empty come from the registered occupancy, so a pop while full never makes room for a push in the same cycle.
module br_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output T                         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the head slot simply shows stale data while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/br_service_bridge.sv
// BrLite service bridge between the DMNI register block and the router local port.
// Optional feature: define BR_SELF_FILTER_EN to acknowledge but drop deliveries carrying the node's own source.
module br_service_bridge
  import DMNIPkg::*;
#(
  parameter logic [15:0] ADDRESS       = 16'b0,
  parameter int          RX_FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ni_req_i,
  output logic        ni_ack_o,
  input  br_payload_t ni_data_i,
  output logic        ni_busy_o,
  output logic        ni_rx_o,
  output br_payload_t ni_data_o,
  input  logic        ni_ack_i,
  output logic        router_req_o,
  input  logic        router_ack_i,
  output br_payload_t router_data_o,
  input  logic        router_req_i,
  output logic        router_ack_o,
  input  br_payload_t router_data_i
);

  localparam logic [7:0] SRC      = br_compact_src(ADDRESS);
  localparam int         RX_CNT_W = $clog2(RX_FIFO_DEPTH) + 1;

  br_tx_state_t        state_q, state_d;
  logic [BR_SEQ_W-1:0] seq_q, seq_d;
  br_payload_t         tx_data_q, tx_data_d;
  logic                ni_ack_q, ni_ack_d;
  logic                router_ack_q;

  logic                rx_self;
  logic                rx_accept;
  logic                rx_push;
  logic                rx_pop;
  logic                rx_full;
  logic                rx_empty;
  logic [RX_CNT_W-1:0] rx_count;

  // The ni_ack_o guard stops a still-dropping NI request from being latched twice.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    tx_data_d = tx_data_q;
    ni_ack_d  = 1'b0;
    case (state_q)
      BR_TX_IDLE: begin
        if (ni_req_i && !ni_ack_q) begin
          state_d              = BR_TX_SEND;
          tx_data_d            = ni_data_i;
          tx_data_d.seq_source = {seq_q, SRC};
          ni_ack_d             = 1'b1;
        end
      end
      BR_TX_SEND: begin
        if (router_ack_i) begin
          state_d = BR_TX_IDLE;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: state_d = BR_TX_IDLE;
    endcase
  end

`ifdef BR_SELF_FILTER_EN
  assign rx_self = (router_data_i.seq_source[7:0] == SRC);
`else
  assign rx_self = 1'b0;
`endif

  // Self packets are always acknowledged, even when full, since they never occupy a slot.
  assign rx_accept = router_req_i && !router_ack_q && (!rx_full || rx_self);
  assign rx_push   = rx_accept && !rx_self;
  assign rx_pop    = ni_ack_i && !rx_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= BR_TX_IDLE;
      seq_q        <= '0;
      tx_data_q    <= '0;
      ni_ack_q     <= 1'b0;
      router_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      tx_data_q    <= tx_data_d;
      ni_ack_q     <= ni_ack_d;
      router_ack_q <= rx_accept;
    end
  end

  br_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .T     (br_payload_t)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .data_i  (router_data_i),
    .pop_i   (rx_pop),
    .data_o  (ni_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign ni_ack_o      = ni_ack_q;
  assign ni_busy_o     = (state_q == BR_TX_SEND);
  assign router_req_o  = (state_q == BR_TX_SEND);
  assign router_data_o = tx_data_q;
  assign router_ack_o  = router_ack_q;
  assign ni_rx_o       = (rx_count != '0);

endmodule

// File: tb/tb_br_service_bridge.sv
// Self-checking bench for br_service_bridge: table-driven send vectors, hand-written RX/reset
// sequences, and a randomized receive run checked against a queue-based reference model.
module tb_br_service_bridge;
  import DMNIPkg::*;

  localparam logic [15:0] ADDRESS = 16'h0201;
  localparam int          DEPTH   = 4;
  localparam logic [7:0]  SRC     = 8'h21;
`ifdef BR_SELF_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ni_req_i;
  logic        ni_ack_o;
  br_payload_t ni_data_i;
  logic        ni_busy_o;
  logic        ni_rx_o;
  br_payload_t ni_data_o;
  logic        ni_ack_i;
  logic        router_req_o;
  logic        router_ack_i;
  br_payload_t router_data_o;
  logic        router_req_i;
  logic        router_ack_o;
  br_payload_t router_data_i;

  always #5 clk = ~clk;

  br_service_bridge #(
    .ADDRESS       (ADDRESS),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ni_req_i      (ni_req_i),
    .ni_ack_o      (ni_ack_o),
    .ni_data_i     (ni_data_i),
    .ni_busy_o     (ni_busy_o),
    .ni_rx_o       (ni_rx_o),
    .ni_data_o     (ni_data_o),
    .ni_ack_i      (ni_ack_i),
    .router_req_o  (router_req_o),
    .router_ack_i  (router_ack_i),
    .router_data_o (router_data_o),
    .router_req_i  (router_req_i),
    .router_ack_o  (router_ack_o),
    .router_data_i (router_data_i)
  );

  typedef struct {
    logic [3:0]  ksvc;
    logic [15:0] payload;
    logic [15:0] junk;
    int          ackDelay;
    br_payload_t exp;
  } txVec_t;

  int          checkCount = 0;
  int          passCount  = 0;
  txVec_t      vecs [4];
  br_payload_t ent [5];
  br_payload_t model [$];
  br_payload_t tmp;
  bit          reqActive;
  bit          seen;
  int          held;
  int          delay;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    checkCount++;
    $display("[TB] FAIL %s: wait bound expired or unexpected event", name);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut;
    rst_i = 1'b1;
    tick;
    tick;
    rst_i = 1'b0;
    tick;
  endtask

  // Send one table vector through the TX path and check the handshake and stamped data.
  task automatic applyStimulus(input txVec_t v);
    ni_data_i = '{ksvc: v.ksvc, payload: v.payload, seq_source: v.junk};
    ni_req_i  = 1'b1;
    tick;
    ni_req_i  = 1'b0;
    checkOutput("tx ni_ack pulse", ni_ack_o, 1);
    checkOutput("tx busy", ni_busy_o, 1);
    checkOutput("tx router_req", router_req_o, 1);
    checkOutput("tx router_data", router_data_o, v.exp);
    for (int i = 0; i < v.ackDelay; i++) begin
      tick;
      checkOutput("tx ack single", ni_ack_o, 0);
      checkOutput("tx busy held", ni_busy_o, 1);
    end
    router_ack_i = 1'b1;
    tick;
    router_ack_i = 1'b0;
    checkOutput("tx busy drop", ni_busy_o, 0);
    checkOutput("tx req drop", router_req_o, 0);
  endtask

  task automatic deliver(input br_payload_t d, input string name);
    bit got;
    got           = 1'b0;
    router_req_i  = 1'b1;
    router_data_i = d;
    for (int i = 0; i < 8 && !got; i++) begin
      tick;
      if (router_ack_o) got = 1'b1;
    end
    router_req_i = 1'b0;
    if (!got) failNow(name);
  endtask

  task automatic popCheck(input br_payload_t exp, input string name);
    checkOutput({name, " rx"}, ni_rx_o, 1);
    checkOutput({name, " head"}, ni_data_o, exp);
    ni_ack_i = 1'b1;
    tick;
    ni_ack_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'h3, 16'hBEEF, 16'h0000, 2, '{4'h3, 16'hBEEF, 16'h0021}};
    vecs[1] = '{4'hF, 16'h0000, 16'hFFFF, 0, '{4'hF, 16'h0000, 16'h0121}};
    vecs[2] = '{4'h0, 16'hFFFF, 16'h1234, 3, '{4'h0, 16'hFFFF, 16'h0221}};
    vecs[3] = '{4'h9, 16'h5A5A, 16'h0021, 1, '{4'h9, 16'h5A5A, 16'h0321}};
    for (int i = 0; i < 5; i++) begin
      ent[i].ksvc       = 4'(i + 1);
      ent[i].payload    = 16'hC000 + 16'(i);
      ent[i].seq_source = 16'h5500 + 16'(i);
    end

    rst_i = 1'b1; ni_req_i = 1'b0; ni_data_i = '0; ni_ack_i = 1'b0;
    router_ack_i = 1'b0; router_req_i = 1'b0; router_data_i = '0;
    tick;
    tick;
    checkOutput("reset ni_ack", ni_ack_o, 0);
    checkOutput("reset busy", ni_busy_o, 0);
    checkOutput("reset ni_rx", ni_rx_o, 0);
    checkOutput("reset router_req", router_req_o, 0);
    checkOutput("reset router_ack", router_ack_o, 0);
    checkOutput("reset router_data", router_data_o, 0);
    rst_i = 1'b0;
    tick;

    $display("[TB] table-driven sends");
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

    $display("[TB] 257 back-to-back sends");
    resetDut;
    ni_data_i = '{ksvc: 4'hA, payload: 16'h1234, seq_source: 16'hFFFF};
    ni_req_i  = 1'b1;
    for (int n = 0; n < 257; n++) begin
      seen = 1'b0;
      for (int w = 0; w < 6 && !seen; w++) begin
        tick;
        if (router_req_o) seen = 1'b1;
      end
      if (!seen) begin
        failNow("seq wait for router_req");
        break;
      end
      checkOutput("seq stamp", router_data_o.seq_source, {n[7:0], SRC});
      checkOutput("seq ni_ack", ni_ack_o, 1);
      delay = $urandom_range(0, 2);
      for (int d = 0; d < delay; d++) begin
        tick;
        checkOutput("seq no re-ack", ni_ack_o, 0);
      end
      router_ack_i = 1'b1;
      tick;
      router_ack_i = 1'b0;
      if (n == 256) ni_req_i = 1'b0;
      checkOutput("seq req drop", router_req_o, 0);
    end
    tick;
    checkOutput("seq idle after last", router_req_o, 0);

    $display("[TB] RX backpressure");
    for (int i = 0; i < 4; i++) begin
      deliver(ent[i], "bp deliver");
      checkOutput("bp rx with ack", ni_rx_o, 1);
    end
    router_req_i  = 1'b1;
    router_data_i = ent[4];
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("bp fifth held", router_ack_o, 0);
    end
    checkOutput("bp head before pop", ni_data_o, ent[0]);
    ni_ack_i = 1'b1;
    tick;
    ni_ack_i = 1'b0;
    checkOutput("bp no push on pop-while-full", router_ack_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick;
      if (router_ack_o) seen = 1'b1;
    end
    router_req_i = 1'b0;
    if (!seen) failNow("bp fifth accepted");
    for (int i = 1; i < 5; i++) popCheck(ent[i], "bp order");
    checkOutput("bp drained", ni_rx_o, 0);

    $display("[TB] push and pop same cycle");
    deliver(ent[0], "pp deliver A");
    deliver(ent[1], "pp deliver B");
    tick;
    router_req_i  = 1'b1;
    router_data_i = ent[2];
    ni_ack_i      = 1'b1;
    tick;
    ni_ack_i      = 1'b0;
    router_req_i  = 1'b0;
    checkOutput("pp push acked", router_ack_o, 1);
    checkOutput("pp head advanced", ni_data_o, ent[1]);
    popCheck(ent[1], "pp pop B");
    popCheck(ent[2], "pp pop C");
    checkOutput("pp count was two", ni_rx_o, 0);

    $display("[TB] self delivery");
    tick;
    tmp = '{ksvc: 4'h7, payload: 16'hABCD, seq_source: 16'h0721};
    deliver(tmp, "self deliver");
    if (FILTER) begin
      checkOutput("self filtered", ni_rx_o, 0);
    end else begin
      popCheck(tmp, "self buffered");
    end
    checkOutput("self empty after", ni_rx_o, 0);

    $display("[TB] randomized receive");
    model.delete();
    reqActive = 1'b0;
    held      = 0;
    tick;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (router_ack_o) begin
        if (!reqActive) begin
          failNow("rand spurious router_ack");
        end else begin
          if (!(FILTER && router_data_i.seq_source[7:0] == SRC)) model.push_back(router_data_i);
          reqActive    = 1'b0;
          router_req_i = 1'b0;
          held         = 0;
        end
      end else if (reqActive) begin
        held++;
        if (held > 60) begin
          failNow("rand delivery starved");
          break;
        end
      end
      checkOutput("rand rx level", ni_rx_o, model.size() != 0);
      ni_ack_i = 1'b0;
      if (model.size() != 0) begin
        checkOutput("rand head", ni_data_o, model[0]);
        if ($urandom_range(0, 2) == 0) begin
          ni_ack_i = 1'b1;
          void'(model.pop_front());
        end
      end else if ($urandom_range(0, 7) == 0) begin
        ni_ack_i = 1'b1;
      end
      if (!reqActive && $urandom_range(0, 1) == 1) begin
        tmp.ksvc       = 4'($urandom);
        tmp.payload    = 16'($urandom);
        tmp.seq_source = 16'($urandom);
        if ($urandom_range(0, 5) == 0) tmp.seq_source[7:0] = SRC;
        else if (tmp.seq_source[7:0] == SRC) tmp.seq_source[7:0] = 8'h22;
        router_data_i = tmp;
        router_req_i  = 1'b1;
        reqActive     = 1'b1;
      end
    end
    router_req_i = 1'b0;
    tick;
    ni_ack_i = 1'b0;
    if (router_ack_o && reqActive) begin
      if (!(FILTER && router_data_i.seq_source[7:0] == SRC)) model.push_back(router_data_i);
    end
    while (model.size() != 0) begin
      tmp = model.pop_front();
      popCheck(tmp, "rand drain");
    end
    checkOutput("rand drained", ni_rx_o, 0);

    $display("[TB] reset during send");
    deliver(ent[0], "rst deliver X");
    deliver(ent[1], "rst deliver Y");
    ni_data_i = '{ksvc: 4'h5, payload: 16'h600D, seq_source: 16'h0000};
    ni_req_i  = 1'b1;
    tick;
    ni_req_i  = 1'b0;
    checkOutput("rst in send", ni_busy_o, 1);
    checkOutput("rst pre seq", router_data_o.seq_source, 16'h0121);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("rst router_req", router_req_o, 0);
    checkOutput("rst ni_rx", ni_rx_o, 0);
    checkOutput("rst busy", ni_busy_o, 0);
    checkOutput("rst no ack", router_ack_o, 0);
    tick;
    rst_i = 1'b0;
    tick;
    checkOutput("rst still empty", ni_rx_o, 0);
    ni_req_i = 1'b1;
    tick;
    ni_req_i = 1'b0;
    checkOutput("rst next seq zero", router_data_o, {4'h5, 16'h600D, 16'h0021});
    router_ack_i = 1'b1;
    tick;
    router_ack_i = 1'b0;
    checkOutput("rst final idle", ni_busy_o, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
